// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - multi-pass sequencer driving a downstream combinational shifter
//
// Breaks a shift of up to 2^WIDTH-1 positions into passes through an external
// shifter whose amount field is only WIDTH-2 bits wide. Per-pass limits are
// M0 = min(WIDTH-1, 2^(WIDTH-2)-1) for dir=0 and M1 = min(WIDTH/2, 2^(WIDTH-2)-1)
// for dir=1.
//
// Optional feature macro: SHIFT_SEQ_PASS_COUNT_EN adds output pass_cnt.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   req_valid/req_ready      request handshake
//   req_data, req_amt        value to shift, total shift amount
//   req_dir, req_fill        direction and fill bit for the shifter
//   sh_in, sh_ctrl           operand and control {fill, chunk, dir} to shifter
//   sh_out, sh_ovf           shifter result and shifted-out bits
//   res_valid/res_ready      result handshake
//   res_data, res_ovf        final value, sticky "a 1 was shifted out" flag
//   pass_cnt                 (macro only) passes used by the current operation

module shift_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_data,
    input  logic [WIDTH-1:0] req_amt,
    input  logic             req_dir,
    input  logic             req_fill,
    output logic [WIDTH-1:0] sh_in,
    output logic [WIDTH-1:0] sh_ctrl,
    input  logic [WIDTH-1:0] sh_out,
    input  logic [WIDTH-1:0] sh_ovf,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_ovf
`ifdef SHIFT_SEQ_PASS_COUNT_EN
    ,
    output logic [WIDTH-1:0] pass_cnt
`endif
);

    // Largest amount the WIDTH-2 bit chunk field can carry. For WIDTH >= 8 the
    // field is always wider than needed, so skip the power to avoid overflow.
    localparam int CH_LIM = (WIDTH >= 8) ? WIDTH : (1 << (WIDTH - 2)) - 1;
    localparam int M0     = ((WIDTH - 1) < CH_LIM) ? (WIDTH - 1) : CH_LIM;
    localparam int M1     = ((WIDTH / 2) < CH_LIM) ? (WIDTH / 2) : CH_LIM;
    localparam logic [WIDTH-1:0] M0_W = WIDTH'(M0);
    localparam logic [WIDTH-1:0] M1_W = WIDTH'(M1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PASS = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dir_q, dir_d;
    logic             fill_q, fill_d;
    logic             ovf_q, ovf_d;
`ifdef SHIFT_SEQ_PASS_COUNT_EN
    logic [WIDTH-1:0] cnt_q, cnt_d;
`endif

    logic [WIDTH-1:0] m_dir;
    logic [WIDTH-1:0] chunk;
    logic [WIDTH-1:0] rem_next;

    always_comb begin
        state_d   = state_q;
        work_d    = work_q;
        rem_d     = rem_q;
        dir_d     = dir_q;
        fill_d    = fill_q;
        ovf_d     = ovf_q;
`ifdef SHIFT_SEQ_PASS_COUNT_EN
        cnt_d     = cnt_q;
`endif
        req_ready = 1'b0;
        res_valid = 1'b0;
        res_data  = '0;
        res_ovf   = 1'b0;
        sh_in     = '0;
        sh_ctrl   = '0;

        // chunk never exceeds rem_q, so rem_next cannot wrap
        m_dir    = dir_q ? M1_W : M0_W;
        chunk    = (rem_q < m_dir) ? rem_q : m_dir;
        rem_next = rem_q - chunk;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    work_d  = req_data;
                    rem_d   = req_amt;
                    dir_d   = req_dir;
                    fill_d  = req_fill;
                    ovf_d   = 1'b0;
`ifdef SHIFT_SEQ_PASS_COUNT_EN
                    cnt_d   = '0;
`endif
                    state_d = (req_amt != '0) ? PASS : HOLD;
                end
            end
            PASS: begin
                sh_in   = work_q;
                sh_ctrl = {fill_q, chunk[WIDTH-3:0], dir_q};
                work_d  = sh_out;
                rem_d   = rem_next;
                ovf_d   = ovf_q | (|sh_ovf);
`ifdef SHIFT_SEQ_PASS_COUNT_EN
                cnt_d   = cnt_q + 1'b1;
`endif
                if (rem_next == '0) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                res_valid = 1'b1;
                res_data  = work_q;
                res_ovf   = ovf_q;
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            work_q  <= '0;
            rem_q   <= '0;
            dir_q   <= 1'b0;
            fill_q  <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef SHIFT_SEQ_PASS_COUNT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            rem_q   <= rem_d;
            dir_q   <= dir_d;
            fill_q  <= fill_d;
            ovf_q   <= ovf_d;
`ifdef SHIFT_SEQ_PASS_COUNT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

`ifdef SHIFT_SEQ_PASS_COUNT_EN
    assign pass_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - self-checking bench for shift_sequencer (WIDTH=4)

module tb_shift_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_data;
    logic [3:0] req_amt;
    logic       req_dir;
    logic       req_fill;
    logic [3:0] sh_in;
    logic [3:0] sh_ctrl;
    logic [3:0] sh_out;
    logic [3:0] sh_ovf;
    logic       res_valid;
    logic       res_ready;
    logic [3:0] res_data;
    logic       res_ovf;
`ifdef SHIFT_SEQ_PASS_COUNT_EN
    logic [3:0] pass_cnt;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    // 0: XOR stub, 1: real shifter with fill
    int stub_sel = 0;

    always #5 clk = ~clk;

    shift_sequencer #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_amt   (req_amt),
        .req_dir   (req_dir),
        .req_fill  (req_fill),
        .sh_in     (sh_in),
        .sh_ctrl   (sh_ctrl),
        .sh_out    (sh_out),
        .sh_ovf    (sh_ovf),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_ovf   (res_ovf)
`ifdef SHIFT_SEQ_PASS_COUNT_EN
        ,
        .pass_cnt  (pass_cnt)
`endif
    );

    // Downstream shifter models
    logic [7:0] wide;
    always_comb begin
        wide   = '0;
        sh_out = '0;
        sh_ovf = '0;
        if (stub_sel == 0) begin
            sh_out = sh_in ^ 4'hF;
            sh_ovf = sh_ctrl;
        end else if (!sh_ctrl[0]) begin
            wide = {4'b0, sh_in} << sh_ctrl[2:1];
            if (sh_ctrl[3]) wide = wide | ((8'h01 << sh_ctrl[2:1]) - 8'h01);
            sh_out = wide[3:0];
            sh_ovf = wide[7:4];
        end else begin
            wide = {sh_in, 4'b0} >> sh_ctrl[2:1];
            if (sh_ctrl[3]) wide = wide | ~(8'hFF >> sh_ctrl[2:1]);
            sh_out = wide[7:4];
            sh_ovf = wide[3:0];
        end
    end

    // Whole-amount reference for the real shifter: independent of pass splitting
    function automatic logic [4:0] ref_shift(input logic [3:0] d, input int amt,
                                             input logic dir, input logic fill);
        logic [3:0] r;
        logic       o;
        r = '0;
        o = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (!dir) r[i] = (i >= amt) ? d[i - amt] : fill;
            else      r[i] = (i + amt < 4) ? d[i + amt] : fill;
        end
        for (int k = 0; k < 4; k++) begin
            if (!dir && k >= 4 - amt) o = o | d[k];
            if (dir && k < amt)       o = o | d[k];
        end
        if (amt > 4 && fill) o = 1'b1;
        return {o, r};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    logic [3:0] ctrl_log[16];
    logic [3:0] in_log[16];
    int         nlog;
    logic [3:0] pc_cap;

    // One full transaction; lat counts edges from the accept edge (inclusive)
    // to the first cycle showing res_valid, or -1 on timeout.
    task automatic run_txn(input logic [3:0] d, input logic [3:0] a, input logic dr,
                           input logic f, output logic [3:0] rd, output logic ro,
                           output int lat);
        bit got;
        @(negedge clk);
        req_data  = d;
        req_amt   = a;
        req_dir   = dr;
        req_fill  = f;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        nlog = 0;
        got  = 0;
        lat  = -1;
        rd   = '0;
        ro   = 1'b0;
        pc_cap = '0;
        for (int k = 1; k <= 40 && !got; k++) begin
            @(negedge clk);
            if (res_valid) begin
                got = 1;
                lat = k;
            end else if (nlog < 16) begin
                ctrl_log[nlog] = sh_ctrl;
                in_log[nlog]   = sh_in;
                nlog++;
            end
        end
        if (got) begin
            rd = res_data;
            ro = res_ovf;
`ifdef SHIFT_SEQ_PASS_COUNT_EN
            pc_cap = pass_cnt;
`endif
            res_ready = 1'b1;
            @(posedge clk);
            #1 res_ready = 1'b0;
        end
    endtask

    typedef struct {
        logic [3:0] data;
        logic [3:0] amt;
        logic       dir;
        logic       fill;
        logic [3:0] exp_data;
        logic       exp_ovf;
        int         exp_lat;
    } vec_t;

    vec_t vecs[8];

    logic [3:0] rd;
    logic       ro;
    int         lat;
    logic [4:0] exp5;
    bit         seen;

    initial begin
        vecs[0] = '{4'h5, 4'd5,  1'b0, 1'b1, 4'h5, 1'b1, 3};
        vecs[1] = '{4'hA, 4'd0,  1'b1, 1'b0, 4'hA, 1'b0, 1};
        vecs[2] = '{4'h3, 4'd5,  1'b1, 1'b0, 4'hC, 1'b1, 4};
        vecs[3] = '{4'h6, 4'd3,  1'b0, 1'b0, 4'h9, 1'b1, 2};
        vecs[4] = '{4'h6, 4'd15, 1'b0, 1'b0, 4'h9, 1'b1, 6};
        vecs[5] = '{4'h1, 4'd15, 1'b1, 1'b1, 4'h1, 1'b1, 9};
        vecs[6] = '{4'h0, 4'd1,  1'b1, 1'b0, 4'hF, 1'b1, 2};
        vecs[7] = '{4'hF, 4'd4,  1'b0, 1'b0, 4'hF, 1'b1, 3};

        rst       = 1'b1;
        req_valid = 1'b0;
        req_data  = '0;
        req_amt   = '0;
        req_dir   = 1'b0;
        req_fill  = 1'b0;
        res_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("reset_outputs", {req_ready, res_valid, res_data, res_ovf, sh_in, sh_ctrl},
            {1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0});
`ifdef SHIFT_SEQ_PASS_COUNT_EN
        chk("reset_pass_cnt", pass_cnt, 4'h0);
`endif

        // Table-driven vectors against the XOR stub
        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i].data, vecs[i].amt, vecs[i].dir, vecs[i].fill, rd, ro, lat);
            chk($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
            chk($sformatf("vec%0d_passes", i), nlog, vecs[i].exp_lat - 1);
            chk($sformatf("vec%0d_res_data", i), rd, vecs[i].exp_data);
            chk($sformatf("vec%0d_res_ovf", i), ro, vecs[i].exp_ovf);
`ifdef SHIFT_SEQ_PASS_COUNT_EN
            chk($sformatf("vec%0d_pass_cnt", i), pc_cap, 4'(vecs[i].exp_lat - 1));
`endif
        end

        // Control word sequence, dir=0 fill=1 amt=5
        run_txn(4'h5, 4'd5, 1'b0, 1'b1, rd, ro, lat);
        chk("seq0_ctrl0", ctrl_log[0], 4'b1110);
        chk("seq0_ctrl1", ctrl_log[1], 4'b1100);
        chk("seq0_in0", in_log[0], 4'h5);
        chk("seq0_in1", in_log[1], 4'hA);

        // Control word sequence, dir=1 fill=0 amt=5
        run_txn(4'h3, 4'd5, 1'b1, 1'b0, rd, ro, lat);
        chk("seq1_ctrl0", ctrl_log[0], 4'b0101);
        chk("seq1_ctrl1", ctrl_log[1], 4'b0101);
        chk("seq1_ctrl2", ctrl_log[2], 4'b0011);

        // HOLD stall with a pending request, then immediate re-accept
        @(negedge clk);
        req_data = 4'h5; req_amt = 4'd5; req_dir = 1'b0; req_fill = 1'b1;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            seen = res_valid;
        end
        chk("hold_reached", seen, 1'b1);
        req_data = 4'hF; req_amt = 4'd1; req_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("hold_stable%0d", k), {res_valid, req_ready, res_data, res_ovf},
                {1'b1, 1'b0, 4'h5, 1'b1});
        end
        res_ready = 1'b1;
        req_data = 4'h3; req_amt = 4'd0; req_dir = 1'b0; req_fill = 1'b0;
        @(posedge clk);
        #1 res_ready = 1'b0;
        @(negedge clk);
        chk("after_hold_idle", {req_ready, res_valid}, {1'b1, 1'b0});
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("reaccept_result", {res_valid, res_data, res_ovf}, {1'b1, 4'h3, 1'b0});
        res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;

        // Reset during the second PASS cycle
        @(negedge clk);
        req_data = 4'h5; req_amt = 4'd5; req_dir = 1'b0; req_fill = 1'b1;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("abort_pass1_ctrl", sh_ctrl, 4'b1110);
        @(posedge clk);
        #1;
        chk("abort_pass2_ctrl", sh_ctrl, 4'b1100);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_outputs", {req_ready, res_valid, res_data, res_ovf, sh_in, sh_ctrl},
            {1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0});
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (res_valid) seen = 1;
        end
        chk("abort_no_result", seen, 1'b0);

        // Real shifter sweep vs whole-amount reference
        stub_sel = 1;
        for (int dr = 0; dr < 2; dr++) begin
            for (int f = 0; f < 2; f++) begin
                for (int a = 1; a <= 7; a++) begin
                    for (int d = 0; d < 16; d++) begin
                        run_txn(4'(d), 4'(a), dr[0], f[0], rd, ro, lat);
                        exp5 = ref_shift(4'(d), a, dr[0], f[0]);
                        chk($sformatf("sweep_d%0d_a%0d_dir%0d_f%0d_data", d, a, dr, f),
                            rd, exp5[3:0]);
                        chk($sformatf("sweep_d%0d_a%0d_dir%0d_f%0d_ovf", d, a, dr, f),
                            ro, exp5[4]);
                    end
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 Parameter WIDTH, default 4, data width; legal values SHALL be WIDTH >= 4.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 req_valid  input  1  request present.
REQ-005 req_ready  output  1  request accepted when high together with req_valid.
REQ-006 req_data  input  WIDTH  value to shift.
REQ-007 req_amt  input  WIDTH  total shift amount, 0 to 2^WIDTH-1.
REQ-008 req_dir  input  1  direction bit, passed through to shifter control bit 0.
REQ-009 req_fill  input  1  fill bit, passed through to shifter control bit WIDTH-1.
REQ-010 sh_in  output  WIDTH  operand to downstream combinational shifter.
REQ-011 sh_ctrl  output  WIDTH  shifter control: [WIDTH-1]=fill, [WIDTH-2:1]=pass amount, [0]=dir.
REQ-012 sh_out  input  WIDTH  shifter result.
REQ-013 sh_ovf  input  WIDTH  shifter shifted-out bits.
REQ-014 res_valid  output  1  result present.
REQ-015 res_ready  input  1  result consumed when high together with res_valid.
REQ-016 res_data  output  WIDTH  final shifted value.
REQ-017 res_ovf  output  1  sticky flag: at least one shifted-out bit was 1.

Function
REQ-018 Per-pass limits SHALL be: M0 = min(WIDTH-1, 2^(WIDTH-2)-1) for dir=0; M1 = min(WIDTH/2, 2^(WIDTH-2)-1) for dir=1.
REQ-019 The FSM SHALL have three states: IDLE, PASS, HOLD.
REQ-020 IDLE: req_ready=1; on req_valid, capture data into work reg, amt into remaining reg, dir and fill; clear ovf; go to PASS if amt!=0, else go to HOLD.
REQ-021 PASS: chunk = min(remaining, M_dir); sh_in = work, sh_ctrl = {fill, chunk, dir}; each edge loads work<=sh_out, remaining<=remaining-chunk, ovf<=ovf | (|sh_ovf).
REQ-022 PASS SHALL go to HOLD on the edge where remaining-chunk==0.
REQ-023 Outside PASS, sh_in SHALL be 0 and sh_ctrl SHALL be 0.
REQ-024 HOLD: res_valid=1; res_data=work; res_ovf=ovf; both SHALL be stable until res_ready; on res_ready go to IDLE.
REQ-025 Latency: with P = ceil(amt/M_dir), res_valid SHALL rise P+1 cycles after the accept edge; for amt=0 it SHALL rise 1 cycle after.
REQ-026 req_ready SHALL be 0 in PASS and HOLD; req_valid SHALL then be ignored, with no state change.
REQ-027 No back-to-back acceptance: the cycle after HOLD->IDLE, req_ready=1.
REQ-028 Arithmetic on remaining SHALL be WIDTH-bit unsigned and SHALL never underflow, because chunk <= remaining.

Reset
REQ-029 rst high at a clock edge SHALL force IDLE; work, remaining, ovf, dir and fill SHALL be 0; res_valid=0, res_data=0, res_ovf=0, sh_in=0, sh_ctrl=0.
REQ-030 Reset mid-PASS or mid-HOLD SHALL abort the operation with no result delivered; req_ready=1 on the first cycle after reset deasserts.

Configuration
REQ-031 Macro SHIFT_SEQ_PASS_COUNT_EN, when defined, SHALL add output pass_cnt [WIDTH-1:0]: number of shifter passes used, cleared on accept and on reset, incremented each PASS edge, and held in HOLD.
REQ-032 Without SHIFT_SEQ_PASS_COUNT_EN, port pass_cnt and its counter SHALL be absent; all other behaviour is identical.

Verification (WIDTH=4, M0=3, M1=2; shifter stub: sh_out = sh_in ^ 4'hF, sh_ovf = sh_ctrl)
REQ-033 Accept data=4'h5, amt=5, dir=0, fill=1 -> sh_ctrl=4'b1110, then 4'b1100; res_valid 3 cycles after accept; res_data=4'h5; res_ovf=1.
REQ-034 Accept data=4'hA, amt=0, dir=1 -> no PASS cycles, sh_ctrl stays 0; res_valid 1 cycle after accept; res_data=4'hA; res_ovf=0.
REQ-035 Accept amt=5, dir=1, fill=0 -> sh_ctrl 4'b0101, 4'b0101, 4'b0011; res_valid 4 cycles after accept; pass_cnt=3 when the macro is defined.
REQ-036 Hold res_ready=0 for 5 cycles in HOLD with req_valid=1 -> res_data and res_ovf stable, req_ready=0, no new accept; res_ready=1 -> IDLE; the next request is accepted the following cycle.
REQ-037 Assert rst during the second PASS cycle of the REQ-033 request -> next cycle state is IDLE, all outputs 0, no res_valid pulse.
REQ-038 Real-shifter check: connect the downstream shifter with OP=0 and OP=1, sweep all data values at amt=1..7 for both dir values -> res_data equals repeated single passes of the shifter chained in software.
